stream_msg_receiver: RTL
========================

Name: stream_msg_receiver

Overview:
- Sink end of the byte-wide AXI-Stream message link.
- Parses frames of the form: 2-byte big-endian length header, then the payload, with tlast on the final byte.
- Stores the payload in an internal buffer, checks the header length against the observed frame length and flags errors.
- Holds the result for a downstream reader until it acknowledges. Sits at the RX side of a loopback or MAC path, opposite the message stream generator.

Parameters:
- MAX_LEN, 64: payload buffer depth in bytes. Range 1..65535.
- EXP_LEN, 11: expected payload length. Used only with MSG_CHECK_EN.
- EXP_MSG, "HELLO WORLD": expected payload, 8*EXP_LEN bits, first byte in the MSBs. Used only with MSG_CHECK_EN.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- tvalid  in  1  stream data valid
- tready  out  1  stream ready (registered)
- tlast  in  1  last byte of frame
- tdata  in  8  stream byte
- frame_valid  out  1  frame result held; high in HOLD
- frame_ack  in  1  single-cycle release of the held frame
- frame_len  out  16  header length value of the held frame
- rx_count  out  16  payload bytes received (saturates at 65535)
- len_err  out  1  header length disagrees with tlast position
- ovf_err  out  1  header length > MAX_LEN
- frame_cnt  out  16  count of error-free frames (wraps)
- rd_addr  in  clog2(MAX_LEN)  buffer read address
- rd_data  out  8  buffer byte at rd_addr, registered

Behaviour:
- Reset: every output is 0 and the state is HDR_HI. tready rises in the first clk edge after reset_n deasserts.
- Beat: tvalid && tready at a posedge. tdata and tlast are sampled only on a beat.
- States:
  - HDR_HI: a beat loads frame_len[15:8].
    - tlast on this beat -> len_err=1, go to HOLD.
  - HDR_LO: a beat loads frame_len[7:0]; ovf_err = (len > MAX_LEN).
    - tlast with len==0 -> good frame, go to HOLD.
    - tlast with len>0 -> len_err, go to HOLD.
    - len==0 without tlast -> len_err, go to DRAIN.
    - otherwise go to PAYLOAD.
  - PAYLOAD: a beat writes tdata to buf[rx_count] only if rx_count < MAX_LEN; rx_count increments.
    - tlast with rx_count+1 == frame_len -> HOLD.
    - tlast with rx_count+1 != frame_len -> len_err, HOLD.
    - rx_count+1 == frame_len without tlast -> len_err, DRAIN.
  - DRAIN: accept and discard beats; rx_count keeps counting. tlast -> HOLD.
  - HOLD: tready=0, frame_valid=1, outputs stable.
    - frame_ack -> next cycle: frame_valid=0; len_err, ovf_err, rx_count and frame_len cleared; tready=1; state HDR_HI.
    - frame_ack outside HOLD is ignored.
- tready timing: registered, so it drops in the cycle after the frame-completing beat. No beat is accepted in HOLD.
- frame_cnt: increments on entry to HOLD iff len_err==0 and ovf_err==0 for that frame.
- Overflow: ovf_err does not stop reception or length checking. Bytes beyond MAX_LEN are counted but not stored.
- rd_data: buf[rd_addr] one clk after rd_addr is presented. Valid any time; content is defined only for addresses < min(frame_len, MAX_LEN) while frame_valid=1.
- tvalid dropping mid-frame is legal: state and counters hold.
- Reset mid-frame: immediate return to reset values. The partial frame is lost and buffer contents are undefined.

Optional Feature:
- Macro: MSG_CHECK_EN.
- Defined:
  - Adds output msg_match (1 bit).
  - During PAYLOAD, each stored byte is compared with EXP_MSG[idx].
  - msg_match is set in HOLD iff no mismatch, frame_len == EXP_LEN, and len_err == ovf_err == 0.
  - msg_match is cleared with the frame on ack; reset value 0.
- Undefined: no msg_match port, no comparison logic, and EXP_LEN/EXP_MSG are unused.

Test Plan:
- Good frame: 0x00,0x0B,"HELLO WORLD" with tlast on 'D', tvalid continuous -> frame_valid=1, frame_len=11, rx_count=11, errors 0, frame_cnt=1, rd_addr=4 gives rd_data=0x4F next cycle; with MSG_CHECK_EN, msg_match=1.
- Backpressure: a second frame sent before ack -> tready=0 from the cycle after the first tlast beat until the cycle after frame_ack; the second frame is then received intact, frame_cnt=2.
- Short frame: header 0x00,0x0B, tlast on the 5th payload byte -> len_err=1, rx_count=5, frame_cnt unchanged.
- Long frame: header 0x00,0x03, 6 payload bytes, tlast on the 6th -> len_err=1, DRAIN consumes the extra 3, rx_count=6, HOLD after the 6th byte.
- Overflow with MAX_LEN=4: header 0x00,0x08, 8 bytes with correct tlast -> ovf_err=1, len_err=0, buf[0..3] hold the first 4 bytes, rx_count=8.
- Reset mid-payload: reset_n pulsed low after 3 payload bytes -> all outputs 0 immediately, tready=1 after release, and the next good frame parses correctly.

Source files
------------

// File: rtl/stream_msg_receiver.sv
// stream_msg_receiver: sink of the byte-wide length-prefixed message stream.
// Frame = 2-byte big-endian length header, payload, tlast on the final byte.
// Payload is buffered (first MAX_LEN bytes), the header length is checked
// against the tlast position, and the result is held until frame_ack.
// Optional build macro MSG_CHECK_EN adds msg_match, which compares the payload
// against EXP_MSG. EXP_LEN/EXP_MSG exist only in that build.
module stream_msg_receiver #(
  parameter int MAX_LEN = 64
`ifdef MSG_CHECK_EN
  ,
  parameter int EXP_LEN = 11,
  parameter logic [8*EXP_LEN-1:0] EXP_MSG = "HELLO WORLD"
`endif
  ,
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          tvalid,
  output logic          tready,
  input  logic          tlast,
  input  logic [7:0]    tdata,
  output logic          frame_valid,
  input  logic          frame_ack,
  output logic [15:0]   frame_len,
  output logic [15:0]   rx_count,
  output logic          len_err,
  output logic          ovf_err,
  output logic [15:0]   frame_cnt,
`ifdef MSG_CHECK_EN
  output logic          msg_match,
`endif
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  typedef enum logic [2:0] {HDR_HI, HDR_LO, PAYLOAD, DRAIN, HOLD} state_t;

  localparam logic [16:0] MAX_L17 = 17'(MAX_LEN);

  state_t      state_q, state_d;
  logic        tready_q, tready_d;
  logic [15:0] frame_len_q, frame_len_d;
  logic [15:0] rx_count_q, rx_count_d;
  logic        len_err_q, len_err_d;
  logic        ovf_err_q, ovf_err_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        beat, wr_en, hold_entry;
  logic [AW-1:0] wr_addr;
  logic [16:0] cnt_inc;
  logic [15:0] rx_sat, hdr_len;
  logic [7:0]  mem_q [MAX_LEN];

  // Frame parser: next state, header/length checks, counters.
  always_comb begin
    state_d     = state_q;
    frame_len_d = frame_len_q;
    rx_count_d  = rx_count_q;
    len_err_d   = len_err_q;
    ovf_err_d   = ovf_err_q;
    frame_cnt_d = frame_cnt_q;
    wr_en       = 1'b0;
    wr_addr     = rx_count_q[AW-1:0];
    beat        = tvalid && tready_q;
    cnt_inc     = {1'b0, rx_count_q} + 17'd1;
    rx_sat      = (&rx_count_q) ? rx_count_q : rx_count_q + 16'd1;
    hdr_len     = {frame_len_q[15:8], tdata};
    case (state_q)
      HDR_HI: if (beat) begin
        frame_len_d[15:8] = tdata;
        if (tlast) begin
          len_err_d = 1'b1;
          state_d   = HOLD;
        end else begin
          state_d = HDR_LO;
        end
      end
      HDR_LO: if (beat) begin
        frame_len_d[7:0] = tdata;
        ovf_err_d        = {1'b0, hdr_len} > MAX_L17;
        if (tlast) begin
          len_err_d = (hdr_len != 16'd0);
          state_d   = HOLD;
        end else if (hdr_len == 16'd0) begin
          len_err_d = 1'b1;
          state_d   = DRAIN;
        end else begin
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: if (beat) begin
        wr_en      = {1'b0, rx_count_q} < MAX_L17;
        rx_count_d = rx_sat;
        if (tlast) begin
          len_err_d = (cnt_inc != {1'b0, frame_len_q});
          state_d   = HOLD;
        end else if (cnt_inc == {1'b0, frame_len_q}) begin
          // header length reached but the frame keeps going
          len_err_d = 1'b1;
          state_d   = DRAIN;
        end
      end
      DRAIN: if (beat) begin
        rx_count_d = rx_sat;
        if (tlast) state_d = HOLD;
      end
      HOLD: if (frame_ack) begin
        state_d     = HDR_HI;
        frame_len_d = 16'd0;
        rx_count_d  = 16'd0;
        len_err_d   = 1'b0;
        ovf_err_d   = 1'b0;
      end
      default: state_d = HDR_HI;
    endcase
    hold_entry = (state_q != HOLD) && (state_d == HOLD);
    if (hold_entry && !len_err_d && !ovf_err_d) frame_cnt_d = frame_cnt_q + 16'd1;
    // registered ready: drops the cycle after the completing beat
    tready_d  = (state_d != HOLD);
    rd_data_d = mem_q[rd_addr];
  end

  // State and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HDR_HI;
      tready_q    <= 1'b0;
      frame_len_q <= 16'd0;
      rx_count_q  <= 16'd0;
      len_err_q   <= 1'b0;
      ovf_err_q   <= 1'b0;
      frame_cnt_q <= 16'd0;
      rd_data_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      tready_q    <= tready_d;
      frame_len_q <= frame_len_d;
      rx_count_q  <= rx_count_d;
      len_err_q   <= len_err_d;
      ovf_err_q   <= ovf_err_d;
      frame_cnt_q <= frame_cnt_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Payload buffer; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= tdata;
  end

`ifdef MSG_CHECK_EN
  logic                   mism_q, mism_d;
  logic                   msg_match_q, msg_match_d;
  logic [8*EXP_LEN-1:0]   exp_sh;

  // Compare each stored byte against the expected message; latch result on HOLD entry.
  always_comb begin
    mism_d      = mism_q;
    msg_match_d = msg_match_q;
    exp_sh      = EXP_MSG << {rx_count_q, 3'b000};
    if (wr_en && (({1'b0, rx_count_q} >= 17'(EXP_LEN)) || (tdata != exp_sh[8*EXP_LEN-1 -: 8])))
      mism_d = 1'b1;
    if (hold_entry)
      msg_match_d = !mism_d && (frame_len_d == 16'(EXP_LEN)) && !len_err_d && !ovf_err_d;
    if ((state_q == HOLD) && frame_ack) begin
      mism_d      = 1'b0;
      msg_match_d = 1'b0;
    end
  end

  // Message-check registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mism_q      <= 1'b0;
      msg_match_q <= 1'b0;
    end else begin
      mism_q      <= mism_d;
      msg_match_q <= msg_match_d;
    end
  end

  assign msg_match = msg_match_q;
`endif

  assign tready      = tready_q;
  assign frame_valid = (state_q == HOLD);
  assign frame_len   = frame_len_q;
  assign rx_count    = rx_count_q;
  assign len_err     = len_err_q;
  assign ovf_err     = ovf_err_q;
  assign frame_cnt   = frame_cnt_q;
  assign rd_data     = rd_data_q;

endmodule
